// File: rtl/eth_regs_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS config words to eth_regs on a start pulse, then optionally reads them back and compares.
// Latency: 2 cycles per write and 2 per read against a zero-wait slave; done/error appear 4*NUM_REGS+1 cycles after start (VERIFY=1).
// Backpressure: each valid is held, with stable payload, until its ready; a phase stalled for TIMEOUT_CYCLES aborts with err_code 3.
module eth_regs_cfg_sequencer #(
   parameter int NUM_REGS       = 4,
   parameter int ADDR_WIDTH     = 4,
   parameter int BASE_ADDR      = 0,
   parameter bit VERIFY         = 1'b1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic                       start,
   input  logic [NUM_REGS*32-1:0]     cfg_data,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [1:0]                 err_code,
   output logic [$clog2(NUM_REGS):0]  err_index,
   output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
   output logic [2:0]                 m_axi_awprot,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [31:0]                m_axi_wdata,
   output logic [3:0]                 m_axi_wstrb,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready,
   output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
   output logic [2:0]                 m_axi_arprot,
   output logic                       m_axi_arvalid,
   input  logic                       m_axi_arready,
   input  logic [31:0]                m_axi_rdata,
   input  logic [1:0]                 m_axi_rresp,
   input  logic                       m_axi_rvalid,
   output logic                       m_axi_rready
);

   localparam int IDX_W = $clog2(NUM_REGS) + 1;
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_FIN, S_FAIL
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [TMR_W-1:0]             tmr_q, tmr_d;
   logic [NUM_REGS-1:0][31:0]    cfg_q;
   logic                         cfg_load;
   logic                         awvalid_q, awvalid_d;
   logic                         wvalid_q, wvalid_d;
   logic                         arvalid_q, arvalid_d;
   logic                         done_q, done_d;
   logic                         error_q, error_d;
   logic [1:0]                   err_code_q, err_code_d;
   logic [IDX_W-1:0]             err_idx_q, err_idx_d;
   logic                         fail;
   logic [1:0]                   fail_code;
   logic                         aw_left, w_left;
   logic                         tmr_expired;
   logic [31:0]                  cur_word;

   // The register index alone determines address and data, so both stay stable while a valid is held.
   assign cur_word      = cfg_q[idx_q[SEL_W-1:0]];
   assign m_axi_awaddr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({idx_q, 2'b00});
   assign m_axi_araddr  = m_axi_awaddr;
   assign m_axi_wdata   = cur_word;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_bready  = (state_q == S_WR_RESP);
   assign m_axi_rready  = (state_q == S_RD_RESP);
   assign busy          = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                          (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign err_index     = err_idx_q;
   assign tmr_expired   = (tmr_q == TMR_LAST);

   // Next-state, handshake bookkeeping and status updates for the sequencer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      done_d     = done_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      err_idx_d  = err_idx_q;
      cfg_load   = 1'b0;
      fail       = 1'b0;
      fail_code  = 2'd0;
      aw_left    = awvalid_q & ~m_axi_awready;
      w_left     = wvalid_q & ~m_axi_wready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WR_REQ;
               idx_d      = '0;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
               err_code_d = 2'd0;
               cfg_load   = 1'b1;
            end
         end
         S_WR_REQ: begin
            // AW and W complete independently; each valid drops right after its own handshake.
            awvalid_d = aw_left;
            wvalid_d  = w_left;
            if (!aw_left && !w_left) begin
               state_d = S_WR_RESP;
            end else if (tmr_expired) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end
         end
         S_WR_RESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) begin
                  fail      = 1'b1;
                  fail_code = 2'd1;
               end else if (idx_q == LAST_IDX) begin
                  idx_d     = '0;
                  state_d   = VERIFY ? S_RD_REQ : S_FIN;
                  arvalid_d = VERIFY;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end
            end else if (tmr_expired) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end
         end
         S_RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_RESP;
            end else if (tmr_expired) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end
         end
         S_RD_RESP: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp != 2'b00) begin
                  fail      = 1'b1;
                  fail_code = 2'd1;
               end else if (m_axi_rdata != cur_word) begin
                  fail      = 1'b1;
                  fail_code = 2'd2;
               end else if (idx_q == LAST_IDX) begin
                  state_d = S_FIN;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  state_d   = S_RD_REQ;
                  arvalid_d = 1'b1;
               end
            end else if (tmr_expired) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end
         end
         S_FIN:   state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Status is registered on entry so done/error are visible in the FIN/FAIL cycle itself.
      if (state_d == S_FIN && state_q != S_FIN) begin
         done_d = 1'b1;
      end
      if (fail) begin
         state_d    = S_FAIL;
         awvalid_d  = 1'b0;
         wvalid_d   = 1'b0;
         arvalid_d  = 1'b0;
         error_d    = 1'b1;
         err_code_d = fail_code;
         err_idx_d  = idx_q;
      end

      // Phase timer restarts on every state change, including a return to the same kind of phase.
      if ((state_d != state_q) || (state_q == S_IDLE)) begin
         tmr_d = '0;
      end else begin
         tmr_d = tmr_q + TMR_W'(1);
      end
   end

   // State, control and status registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         tmr_q      <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'd0;
         err_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tmr_q      <= tmr_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         arvalid_q  <= arvalid_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         err_idx_q  <= err_idx_d;
      end
   end

   // Configuration words are captured only on an accepted start.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cfg_q <= '0;
      end else if (cfg_load) begin
         cfg_q <= cfg_data;
      end
   end

endmodule

// File: tb/tb_eth_regs_cfg_sequencer.sv
module tb_eth_regs_cfg_sequencer;

   logic ACLK = 1'b0;
   logic ARESETN;
   always #5 ACLK = ~ACLK;

   // ---------------- DUT 1: VERIFY=1 ----------------
   logic         start;
   logic [127:0] cfg_data;
   logic         busy, done, error;
   logic [1:0]   err_code;
   logic [2:0]   err_index;
   logic [3:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;

   eth_regs_cfg_sequencer #(.NUM_REGS(4), .ADDR_WIDTH(4), .BASE_ADDR(0), .VERIFY(1'b1), .TIMEOUT_CYCLES(255)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // ---------------- DUT 2: VERIFY=0 ----------------
   logic         start2;
   logic [127:0] cfg_data2;
   logic         busy2, done2, error2;
   logic [1:0]   err_code2;
   logic [2:0]   err_index2;
   logic [3:0]   awaddr2, araddr2;
   logic [2:0]   awprot2, arprot2;
   logic         awvalid2, awready2, wvalid2, wready2, bvalid2, bready2;
   logic         arvalid2, arready2, rvalid2, rready2;
   logic [31:0]  wdata2, rdata2;
   logic [3:0]   wstrb2;
   logic [1:0]   bresp2, rresp2;

   eth_regs_cfg_sequencer #(.NUM_REGS(4), .ADDR_WIDTH(4), .BASE_ADDR(0), .VERIFY(1'b0), .TIMEOUT_CYCLES(255)) dut2 (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start2), .cfg_data(cfg_data2),
      .busy(busy2), .done(done2), .error(error2), .err_code(err_code2), .err_index(err_index2),
      .m_axi_awaddr(awaddr2), .m_axi_awprot(awprot2), .m_axi_awvalid(awvalid2), .m_axi_awready(awready2),
      .m_axi_wdata(wdata2), .m_axi_wstrb(wstrb2), .m_axi_wvalid(wvalid2), .m_axi_wready(wready2),
      .m_axi_bresp(bresp2), .m_axi_bvalid(bvalid2), .m_axi_bready(bready2),
      .m_axi_araddr(araddr2), .m_axi_arprot(arprot2), .m_axi_arvalid(arvalid2), .m_axi_arready(arready2),
      .m_axi_rdata(rdata2), .m_axi_rresp(rresp2), .m_axi_rvalid(rvalid2), .m_axi_rready(rready2)
   );

   // ---------------- slave models ----------------
   bit        tb_clr;
   int        aw_delay, bad_b, bad_r;
   bit        r_hang;
   int        aw_n, w_n, ar_n, b_n, r_n, aw_cnt, aw_hi, w_hi;
   bit        aw_got, w_got, b_pend, r_pend;
   bit [3:0]  cur_a, r_a;
   bit [31:0] cur_d;
   bit [31:0] mem [4];
   bit [31:0] aw_log [32];
   bit [31:0] w_log [32];
   bit [31:0] ar_log [32];
   int        aw2_n, ar2_n;
   bit        b2_pend;
   bit [31:0] w2_log [16];
   bit [31:0] a2_log [16];

   // Handshakes are sampled on the active edge; slave state updates here.
   always @(posedge ACLK) begin : slave_sample
      bit        na, nw;
      bit [3:0]  a_now;
      bit [31:0] d_now;
      if (tb_clr) begin
         aw_n <= 0; w_n <= 0; ar_n <= 0; b_n <= 0; r_n <= 0;
         aw_cnt <= 0; aw_hi <= 0; w_hi <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw2_n <= 0; ar2_n <= 0; b2_pend <= 1'b0;
      end else begin
         if (awvalid) aw_hi <= aw_hi + 1;
         if (wvalid)  w_hi  <= w_hi + 1;
         if (awvalid && awready) begin
            aw_log[aw_n % 32] <= {28'd0, awaddr};
            aw_n   <= aw_n + 1;
            aw_cnt <= 0;
            cur_a  <= awaddr;
         end else if (awvalid) begin
            aw_cnt <= aw_cnt + 1;
         end
         if (wvalid && wready) begin
            w_log[w_n % 32] <= wdata;
            w_n   <= w_n + 1;
            cur_d <= wdata;
         end
         na    = aw_got || (awvalid && awready);
         nw    = w_got || (wvalid && wready);
         a_now = (awvalid && awready) ? awaddr : cur_a;
         d_now = (wvalid && wready) ? wdata : cur_d;
         if (bvalid && bready) begin
            b_pend <= 1'b0;
            b_n    <= b_n + 1;
         end
         if (na && nw) begin
            mem[a_now[3:2]] <= d_now;
            b_pend <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else begin
            aw_got <= na;
            w_got  <= nw;
         end
         if (rvalid && rready) begin
            r_pend <= 1'b0;
            r_n    <= r_n + 1;
         end
         if (arvalid && arready) begin
            ar_log[ar_n % 32] <= {28'd0, araddr};
            ar_n   <= ar_n + 1;
            r_pend <= 1'b1;
            r_a    <= araddr;
         end
         // Second slave: always ready, B one cycle after the write.
         if (bvalid2 && bready2) b2_pend <= 1'b0;
         if (awvalid2 && wvalid2) begin
            b2_pend <= 1'b1;
            w2_log[aw2_n % 16] <= wdata2;
            a2_log[aw2_n % 16] <= {28'd0, awaddr2};
            aw2_n <= aw2_n + 1;
         end
         if (arvalid2) ar2_n <= ar2_n + 1;
      end
   end

   // Slave outputs change on the inactive edge.
   always @(negedge ACLK) begin : slave_drive
      awready = (aw_cnt >= aw_delay);
      wready  = 1'b1;
      bvalid  = b_pend;
      bresp   = (b_pend && (b_n == bad_b)) ? 2'b10 : 2'b00;
      arready = 1'b1;
      rvalid  = r_pend && !r_hang;
      rdata   = mem[r_a[3:2]] ^ ((r_n == bad_r) ? 32'd1 : 32'd0);
      rresp   = 2'b00;
      bvalid2 = b2_pend;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_slave();
      @(negedge ACLK); tb_clr = 1'b1;
      @(negedge ACLK); tb_clr = 1'b0;
   endtask

   // Returns on the negedge of the first cycle after the accepting edge.
   task automatic pulse_start(input logic [127:0] c);
      @(negedge ACLK); start = 1'b1; cfg_data = c;
      @(negedge ACLK); start = 1'b0;
   endtask

   // Counts negedges (first returned cycle = 1) until done or error, bounded.
   task automatic wait_end(output int cyc);
      cyc = 1;
      while (!done && !error && cyc < 600) begin
         @(negedge ACLK);
         cyc++;
      end
   endtask

   localparam logic [127:0] CFG_A = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] CFG_B = {32'hDEAD0003, 32'hCAFE0002, 32'hBEEF0001, 32'h12340000};
   localparam logic [127:0] CFG_X = {4{32'hFFFFFFFF}};

   initial begin
      int cyc;
      logic [127:0] cb;
      ARESETN = 1'b0; start = 1'b0; cfg_data = '0; start2 = 1'b0; cfg_data2 = '0;
      tb_clr = 1'b1; aw_delay = 0; bad_b = -1; bad_r = -1; r_hang = 1'b0;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; arready = 1'b1;
      rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      awready2 = 1'b1; wready2 = 1'b1; bvalid2 = 1'b0; bresp2 = 2'b00; arready2 = 1'b1;
      rvalid2 = 1'b0; rdata2 = '0; rresp2 = 2'b00;

      // Reset state
      repeat (3) @(negedge ACLK);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst error", error, 0);
      chk("rst err_code", err_code, 0);
      chk("rst err_index", err_index, 0);
      chk("rst valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      chk("rst wstrb", wstrb, 32'hF);
      ARESETN = 1'b1;
      tb_clr  = 1'b0;
      @(negedge ACLK);

      // T1: nominal write + verify, zero-wait slave
      clr_slave();
      pulse_start(CFG_A);
      chk("T1 busy c1", busy, 1);
      chk("T1 aw/w valid c1", {awvalid, wvalid}, 2'b11);
      chk("T1 awprot", awprot, 0);
      wait_end(cyc);
      chk("T1 start->done cycles", cyc, 17);
      chk("T1 done", done, 1);
      chk("T1 error", error, 0);
      chk("T1 busy end", busy, 0);
      chk("T1 aw count", aw_n, 4);
      chk("T1 ar count", ar_n, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("T1 awaddr[%0d]", i), aw_log[i], 32'(4 * i));
         chk($sformatf("T1 wdata[%0d]", i), w_log[i], 32'(i + 1));
         chk($sformatf("T1 araddr[%0d]", i), ar_log[i], 32'(4 * i));
      end
      repeat (3) @(negedge ACLK);
      chk("T1 done held", done, 1);

      // T2: awready delayed 3 cycles; also a start while busy must be ignored
      clr_slave();
      aw_delay = 3;
      pulse_start(CFG_B);
      chk("T2 done cleared", done, 0);
      start = 1'b1; cfg_data = CFG_X;
      @(negedge ACLK); start = 1'b0;
      wait_end(cyc);
      chk("T2 done", done, 1);
      chk("T2 error", error, 0);
      chk("T2 awvalid cycles", aw_hi, 16);
      chk("T2 wvalid cycles", w_hi, 4);
      cb = CFG_B;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("T2 wdata[%0d]", i), w_log[i], cb[32*i +: 32]);
         chk($sformatf("T2 awaddr[%0d]", i), aw_log[i], 32'(4 * i));
      end
      aw_delay = 0;

      // T3: SLVERR on write index 2
      clr_slave();
      bad_b = 2;
      pulse_start(CFG_A);
      wait_end(cyc);
      repeat (3) @(negedge ACLK);
      chk("T3 error", error, 1);
      chk("T3 done", done, 0);
      chk("T3 err_code", err_code, 1);
      chk("T3 err_index", err_index, 2);
      chk("T3 aw count", aw_n, 3);
      chk("T3 ar count", ar_n, 0);
      bad_b = -1;

      // T4: read-back mismatch on index 1
      clr_slave();
      bad_r = 1;
      pulse_start(CFG_B);
      wait_end(cyc);
      repeat (3) @(negedge ACLK);
      chk("T4 error", error, 1);
      chk("T4 err_code", err_code, 2);
      chk("T4 err_index", err_index, 1);
      chk("T4 ar count", ar_n, 2);
      chk("T4 aw count", aw_n, 4);
      bad_r = -1;

      // T5: rvalid never comes -> timeout
      clr_slave();
      r_hang = 1'b1;
      pulse_start(CFG_A);
      cyc = 0;
      while (ar_n == 0 && cyc < 100) begin
         @(negedge ACLK);
         cyc++;
      end
      chk("T5 AR seen", ar_n, 1);
      chk("T5 rready waiting", rready, 1);
      cyc = 0;
      while (!error && cyc < 400) begin
         @(negedge ACLK);
         cyc++;
      end
      chk("T5 AR->error cycles", cyc, 255);
      chk("T5 err_code", err_code, 3);
      chk("T5 err_index", err_index, 0);
      chk("T5 rready after", rready, 0);
      chk("T5 done", done, 0);
      r_hang = 1'b0;

      // T6: reset mid-WR_REQ, then normal completion on both variants
      clr_slave();
      aw_delay = 3;
      pulse_start(CFG_A);
      @(negedge ACLK);
      chk("T6 awvalid before rst", awvalid, 1);
      ARESETN = 1'b0;
      #1;
      chk("T6 valids in rst", {awvalid, wvalid, arvalid, bready, rready}, 0);
      chk("T6 busy in rst", busy, 0);
      chk("T6 error in rst", error, 0);
      chk("T6 err_code in rst", err_code, 0);
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      aw_delay = 0;
      clr_slave();
      pulse_start(CFG_B);
      wait_end(cyc);
      chk("T6 restart cycles", cyc, 17);
      chk("T6 restart done", done, 1);

      @(negedge ACLK); start2 = 1'b1; cfg_data2 = CFG_B;
      @(negedge ACLK); start2 = 1'b0;
      chk("T6 v0 busy", busy2, 1);
      cyc = 1;
      while (!done2 && !error2 && cyc < 200) begin
         @(negedge ACLK);
         cyc++;
      end
      chk("T6 v0 start->done cycles", cyc, 9);
      chk("T6 v0 error", error2, 0);
      chk("T6 v0 aw count", aw2_n, 4);
      chk("T6 v0 ar count", ar2_n, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("T6 v0 wdata[%0d]", i), w2_log[i], cb[32*i +: 32]);
         chk($sformatf("T6 v0 awaddr[%0d]", i), a2_log[i], 32'(4 * i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
